// File: rtl/alu_result_serializer_pkg.sv
// Shared widths, beat-index type, FSM state and beat selection for the
// ALU result serializer and the logic-unit wrappers.
package alu_result_serializer_pkg;

  localparam int unsigned RES_W  = 67;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NBEATS = 3;

  typedef logic [1:0] beat_idx_t;

  localparam beat_idx_t LAST_IDX = beat_idx_t'(NBEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  // Select one 32-bit beat from the held result; the top beat is zero-extended.
  function automatic logic [WORD_W-1:0] beat_word(input logic [RES_W-1:0] hold,
                                                  input beat_idx_t         idx);
    case (idx)
      2'd0:    return hold[WORD_W-1:0];
      2'd1:    return hold[2*WORD_W-1:WORD_W];
      default: return {{(3*WORD_W-RES_W){1'b0}}, hold[RES_W-1:2*WORD_W]};
    endcase
  endfunction

endpackage

// File: rtl/alu_result_serializer_fit_check.sv
// Combinational sign-fit detector: the result fits in 32 signed bits when
// bits 66:31 are all zeros or all ones. Shared with the shifter path.
module result_fit_check
  import alu_result_serializer_pkg::*;
(
  input  logic [RES_W-WORD_W:0] upper_i,
  output logic                  fits32_o
);

  // Sign extension check over the upper slice (bit 31 included).
  always_comb begin
    fits32_o = (&upper_i) | ~(|upper_i);
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Serializes a 67-bit ALU result into 32-bit beats over valid/ready, with
// optional single-beat emission when the result fits in 32 signed bits.
module alu_result_serializer
  import alu_result_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RES_W-1:0]  res_in,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic              compact_en,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [1:0]        word_idx,
  output logic              word_last,
  output logic              fits32
);

  state_e            state_q;
  logic [RES_W-1:0]  hold_q;
  beat_idx_t         idx_q;
  beat_idx_t         idx_d;
  logic [WORD_W-1:0] word_out_q;
  logic              word_valid_q;
  logic              word_last_q;
  logic              fits32_q;
  logic              fit_now;
  logic              accept;
  logic              advance;

  result_fit_check u_fit (
    .upper_i  (res_in[RES_W-1:WORD_W-1]),
    .fits32_o (fit_now)
  );

  // Ready in IDLE, or on the final-beat handshake so results chain without a bubble.
  assign res_ready = (state_q == IDLE) || (word_last_q && word_ready);

  assign accept  = res_valid && res_ready;
  assign advance = word_valid_q && word_ready;

  // Next beat index within the current result.
  always_comb begin
    idx_d = beat_idx_t'(idx_q + 2'd1);
  end

  // Capture / beat-advance FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      idx_q        <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      fits32_q     <= 1'b0;
    end else if (accept) begin
      // Beat 0 is taken straight from res_in so it is valid the next cycle.
      state_q      <= SEND;
      hold_q       <= res_in;
      fits32_q     <= fit_now;
      idx_q        <= '0;
      word_out_q   <= res_in[WORD_W-1:0];
      word_valid_q <= 1'b1;
      word_last_q  <= compact_en && fit_now;
    end else if (advance) begin
      if (word_last_q) begin
        state_q      <= IDLE;
        idx_q        <= '0;
        word_out_q   <= '0;
        word_valid_q <= 1'b0;
        word_last_q  <= 1'b0;
      end else begin
        idx_q       <= idx_d;
        word_out_q  <= beat_word(hold_q, idx_d);
        word_last_q <= (idx_d == LAST_IDX);
      end
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign word_idx   = idx_q;
  assign word_last  = word_last_q;
  assign fits32     = fits32_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Scoreboard bench for alu_result_serializer: stimulus pushes hand-computed
// beats, a negedge monitor pops and compares on every beat handshake.
module tb_alu_result_serializer;

  logic        clk;
  logic        rst_n;
  logic [66:0] res_in;
  logic        res_valid;
  logic        res_ready;
  logic        compact_en;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [1:0]  word_idx;
  logic        word_last;
  logic        fits32;

  int vectors = 0;
  int errors  = 0;

  logic [34:0] exp_q[$];

  alu_result_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_in     (res_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .compact_en (compact_en),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_idx   (word_idx),
    .word_last  (word_last),
    .fits32     (fits32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic [1:0] idx, input logic last);
    exp_q.push_back({w, idx, last});
  endtask

  // Monitor: one comparison per accepted beat.
  always @(negedge clk) begin
    logic [34:0] e;
    if (rst_n && word_valid && word_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got word %h idx %0d last %0b, expected none",
                 word_out, word_idx, word_last);
      end else begin
        e = exp_q.pop_front();
        if ({word_out, word_idx, word_last} !== e) begin
          errors++;
          $display("FAIL beat: got word %h idx %0d last %0b, expected word %h idx %0d last %0b",
                   word_out, word_idx, word_last, e[34:3], e[2:1], e[0]);
        end
      end
    end
  end

  // Offer a result, wait for acceptance, scramble inputs, then check fits32 and latency.
  task automatic send(input logic [66:0] r, input logic ce, input logic exp_fit);
    int n;
    res_in     = r;
    compact_en = ce;
    res_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_ready && n < 200);
    if (n >= 200) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    res_valid  = 1'b0;
    res_in     = ~r;
    compact_en = ~ce;
    chk("fits32", fits32, exp_fit);
    chk("latency_valid", word_valid, 1'b1);
    chk("latency_idx0", word_idx, 2'd0);
  endtask

  // Wait for all expected beats, then confirm the FSM has gone idle.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    chk("idle_valid", word_valid, 1'b0);
    chk("idle_ready", res_ready, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    res_in     = '0;
    res_valid  = 1'b0;
    compact_en = 1'b0;
    word_ready = 1'b1;
    #12;
    chk("rst_res_ready", res_ready, 1'b1);
    chk("rst_word_valid", word_valid, 1'b0);
    chk("rst_word_out", word_out, 32'h0);
    chk("rst_word_idx", word_idx, 2'd0);
    chk("rst_word_last", word_last, 1'b0);
    chk("rst_fits32", fits32, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full result without compaction.
    push(32'h00000000, 2'd0, 1'b0);
    push(32'h40010000, 2'd1, 1'b0);
    push(32'h00000000, 2'd2, 1'b1);
    send({3'b000, 32'h40010000, 32'h00000000}, 1'b0, 1'b0);
    drain();

    // Compaction of a positive value.
    push(32'h40010000, 2'd0, 1'b1);
    send(67'h0_0000_0000_4001_0000, 1'b1, 1'b1);
    drain();

    // All ones, compacted and not.
    push(32'hFFFFFFFF, 2'd0, 1'b1);
    send({67{1'b1}}, 1'b1, 1'b1);
    drain();
    push(32'hFFFFFFFF, 2'd0, 1'b0);
    push(32'hFFFFFFFF, 2'd1, 1'b0);
    push(32'h00000007, 2'd2, 1'b1);
    send({67{1'b1}}, 1'b0, 1'b1);
    drain();

    // Bit 31 set with zero upper bits does not fit: three beats despite compact_en.
    push(32'h80000000, 2'd0, 1'b0);
    push(32'h00000000, 2'd1, 1'b0);
    push(32'h00000000, 2'd2, 1'b1);
    send(67'h0_0000_0000_8000_0000, 1'b1, 1'b0);
    drain();

    // Backpressure for 4 cycles on idx1.
    push(32'h01234567, 2'd0, 1'b0);
    push(32'h89ABCDEF, 2'd1, 1'b0);
    push(32'h00000005, 2'd2, 1'b1);
    send({3'b101, 32'h89ABCDEF, 32'h01234567}, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_word", word_out, 32'h89ABCDEF);
      chk("bp_idx", word_idx, 2'd1);
      chk("bp_last", word_last, 1'b0);
      chk("bp_valid", word_valid, 1'b1);
      chk("bp_res_ready", res_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    drain();

    // Back-to-back: second result captured on the first's last beat.
    push(32'hCAFEF00D, 2'd0, 1'b0);
    push(32'hDEADBEEF, 2'd1, 1'b0);
    push(32'h00000002, 2'd2, 1'b1);
    push(32'h80000000, 2'd0, 1'b0);
    push(32'hFFFFFFFF, 2'd1, 1'b0);
    push(32'h00000007, 2'd2, 1'b1);
    res_in     = {3'b010, 32'hDEADBEEF, 32'hCAFEF00D};
    compact_en = 1'b0;
    res_valid  = 1'b1;
    @(negedge clk);
    chk("b2b_first_ready", res_ready, 1'b1);
    @(posedge clk);
    #1;
    res_in = 67'h7_FFFF_FFFF_8000_0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_no_gap", word_valid, 1'b1);
      if (i == 2) begin
        chk("b2b_ready_on_last", res_ready, 1'b1);
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        chk("b2b_fits32", fits32, 1'b1);
        chk("b2b_idx_restart", word_idx, 2'd0);
      end
    end
    drain();

    // Reset asserted during idx1 aborts the transfer.
    push(32'h33334444, 2'd0, 1'b0);
    send({3'b011, 32'h11112222, 32'h33334444}, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_idx", word_idx, 2'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_word_valid", word_valid, 1'b0);
    chk("arst_res_ready", res_ready, 1'b1);
    chk("arst_word_out", word_out, 32'h0);
    chk("arst_word_idx", word_idx, 2'd0);
    chk("arst_fits32", fits32, 1'b0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_ready", res_ready, 1'b1);
    chk("post_rst_valid", word_valid, 1'b0);
    push(32'h7FFFFFFF, 2'd0, 1'b1);
    send(67'h0_0000_0000_7FFF_FFFF, 1'b1, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
